if_stage_param: RTL and testbench

- Parametrised instruction-fetch stage for the pipelined CPU datapath; successor to the fixed 32-bit IF block.
- Holds the PC register and a PC+step adder, and muxes the next PC between the sequential path and a redirect (branch/jump) target.
- Includes a loadable instruction memory and the IF/ID pipeline register with stall, flush and valid tracking.
- Sits between the control/hazard unit (stall, flush, redirect) and the ID stage.

---
 rtl/if_pkg.sv | 43 ++++
 rtl/if_imem.sv | 26 ++
 rtl/if_stage_param.sv | 127 ++++++++++++
 tb/tb_if_stage_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared defaults and selector encodings for the parametrised instruction-fetch stage.
package if_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 8;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_HOLD  = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_sel_e;

  // Next-PC priority: redirect beats stall, stall beats sequential.
  function automatic pc_sel_e pc_select(input logic redirect_valid, input logic pc_write);
    if (redirect_valid)
      return PC_REDIR;
    else if (!pc_write)
      return PC_HOLD;
    else
      return PC_SEQ;
  endfunction

  // IF/ID priority: flush or redirect inserts a bubble, otherwise stall holds.
  function automatic ifid_sel_e ifid_select(input logic flush, input logic redirect_valid,
                                            input logic pc_write);
    if (flush || redirect_valid)
      return IFID_BUBBLE;
    else if (!pc_write)
      return IFID_HOLD;
    else
      return IFID_LOAD;
  endfunction

endpackage

// File: rtl/if_imem.sv
// Instruction memory: 2^ADDR_W words, combinational read port, synchronous write port.
module if_imem
  import if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Contents are deliberately not reset; a same-cycle read sees the old word.
  always_ff @(posedge clock) begin
    if (we)
      mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC register, PC+step adder, redirect mux, imem and IF/ID register.
// Optional build macro IF_MISALIGN_CHECK_EN aligns redirect targets and raises a sticky misalign_err.
module if_stage_param
  import if_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF),
  parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(PC_STEP_DEF),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_target,
  input  logic              flush,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pc_plus,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc_plus,
  output logic              ifid_valid,
  output logic              misalign_err
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0] ifid_pc_plus_q, ifid_pc_plus_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [DATA_W-1:0] pc_plus_w;
  logic [DATA_W-1:0] fetch_instr;
  logic [DATA_W-1:0] redir_pc;
  pc_sel_e           pc_sel;
  ifid_sel_e         ifid_sel;

  // Fetch index drops the byte offset; higher PC bits wrap modulo memory depth.
  if_imem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_imem (
    .clock(clock),
    .we   (imem_we),
    .waddr(imem_waddr),
    .wdata(imem_wdata),
    .raddr(pc_q[ADDR_W+1:2]),
    .rdata(fetch_instr)
  );

  assign pc_plus_w = pc_q + PC_STEP;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redir_pc   = {redirect_target[DATA_W-1:2], 2'b00};
  assign misalign_d = misalign_q | (redirect_valid & (|redirect_target[1:0]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else
      misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign redir_pc     = redirect_target;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    pc_sel   = pc_select(redirect_valid, pc_write);
    ifid_sel = ifid_select(flush, redirect_valid, pc_write);

    pc_d = pc_q;
    case (pc_sel)
      PC_REDIR: pc_d = redir_pc;
      PC_HOLD:  pc_d = pc_q;
      default:  pc_d = pc_plus_w;
    endcase

    ifid_instr_d   = ifid_instr_q;
    ifid_pc_plus_d = ifid_pc_plus_q;
    ifid_valid_d   = ifid_valid_q;
    case (ifid_sel)
      IFID_BUBBLE: begin
        ifid_instr_d   = NOP_WORD;
        ifid_pc_plus_d = '0;
        ifid_valid_d   = 1'b0;
      end
      IFID_HOLD: begin
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_plus_d = ifid_pc_plus_q;
        ifid_valid_d   = ifid_valid_q;
      end
      default: begin
        ifid_instr_d   = fetch_instr;
        ifid_pc_plus_d = pc_plus_w;
        ifid_valid_d   = 1'b1;
      end
    endcase
  end

  // PC / IF-ID register boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      ifid_instr_q   <= NOP_WORD;
      ifid_pc_plus_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_plus_q <= ifid_pc_plus_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

  assign pc_out       = pc_q;
  assign pc_plus      = pc_plus_w;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc_plus = ifid_pc_plus_q;
  assign ifid_valid   = ifid_valid_q;

endmodule

// File: tb/tb_if_stage_param.sv
// Scoreboard bench for if_stage_param: a reference model predicts each cycle's outputs into a queue.
module tb_if_stage_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        flush = 1'b0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] pc_out, pc_plus, ifid_instr, ifid_pc_plus;
  logic        ifid_valid, misalign_err;

  if_stage_param dut (
    .clock          (clock),
    .reset          (reset),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .flush          (flush),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .pc_out         (pc_out),
    .pc_plus        (pc_plus),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus   (ifid_pc_plus),
    .ifid_valid     (ifid_valid),
    .misalign_err   (misalign_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpcp;
    logic        vld;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          fails = 0;

  // Reference model state: architectural view of PC, IF/ID and memory.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_ifpcp = 32'h0;
  logic        m_vld = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_mem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus", pc_plus, e.pc + 32'd4);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.vld});
        chk("ifid_instr", ifid_instr, e.instr);
        if (e.vld) chk("ifid_pc_plus", ifid_pc_plus, e.ifpcp);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
      end
    end
  end

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock); #1;
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    m_mem[a]   = d;
  endtask

  task automatic idle();
    pc_write       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    imem_we        = 1'b0;
  endtask

  task automatic step(input logic pw, input logic rv, input logic [31:0] tgt, input logic fl,
                      input logic we, input logic [7:0] wa, input logic [31:0] wd);
    logic [31:0] fetched, seq, tgt_eff;
    exp_t        e;
    @(negedge clock); #1;
    pc_write        = pw;
    redirect_valid  = rv;
    redirect_target = tgt;
    flush           = fl;
    imem_we         = we;
    imem_waddr      = wa;
    imem_wdata      = wd;

    fetched = m_mem[(m_pc / 4) % 256];
    seq     = m_pc + 32'd4;
    tgt_eff = tgt;
`ifdef IF_MISALIGN_CHECK_EN
    tgt_eff = tgt - (tgt % 4);
    if (rv && (tgt % 4) != 0) m_err = 1'b1;
`endif
    if (fl || rv) begin
      m_instr = 32'h0;
      m_vld   = 1'b0;
    end else if (pw) begin
      m_instr = fetched;
      m_ifpcp = seq;
      m_vld   = 1'b1;
    end
    if (rv)      m_pc = tgt_eff;
    else if (pw) m_pc = seq;
    if (we) m_mem[wa] = wd;

    e.pc = m_pc; e.instr = m_instr; e.ifpcp = m_ifpcp; e.vld = m_vld; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc_out"}, pc_out, 32'h0);
    chk({tag, "_ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, "_ifid_instr"}, ifid_instr, 32'h0);
    chk({tag, "_ifid_pc_plus"}, ifid_pc_plus, 32'h0);
    chk({tag, "_misalign_err"}, {31'b0, misalign_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] cur;
    #1;
    check_reset_values("reset");

    // Preload all words so no fetch is ever undefined, then the directed words.
    for (int i = 0; i < 256; i++) load_word(8'(i), $urandom);
    load_word(8'd0, 32'h11);
    load_word(8'd1, 32'h22);
    load_word(8'd2, 32'h33);
    load_word(8'd3, 32'h44);
    load_word(8'd16, 32'hA5A5_0016);
    @(negedge clock); #1;
    idle();
    reset = 1'b0;

    // Sequential fetch, stall at pc 8, resume.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Redirect during stall, then fetch of mem[16].
    step(0, 1, 32'h40, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Flush with valid IF/ID, then flush while stalled, then flush with redirect.
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 32'h8, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Write/read collision, then redirect back to see the new word.
    cur = m_pc;
    step(1, 0, 0, 0, 1, cur[9:2], 32'hDEAD);
    step(1, 1, cur, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // PC wrap at the top of the address space.
    step(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Misaligned redirect.
    step(1, 1, 32'h42, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-operation, checked between edges.
    @(negedge clock); #2;
    idle();
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    m_pc = 32'h0; m_instr = 32'h0; m_ifpcp = 32'h0; m_vld = 1'b0; m_err = 1'b0;
    @(negedge clock); #1;
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        pw, rv, fl, we;
      logic [31:0] tgt;
      pw  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 4) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? $urandom : {22'b0, 8'($urandom), 2'b00};
      if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step(pw, rv, tgt, fl, we, ($urandom_range(0, 1) == 1) ? m_pc[9:2] : 8'($urandom),
           $urandom);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
